// File: rtl/uart_tx_trigger.sv
// UART transmitter triggered by a one-cycle request pulse.
// Contains the baud divider, frame FSM and a one-deep pending byte buffer.
module uart_tx_trigger #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned DBIT         = 8,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic            clk_100MHz,
   input  logic            reset,
   input  logic            tx_start,
   input  logic [DBIT-1:0] din,
   output logic            tx,
   output logic            tx_busy,
   output logic            tx_done_tick,
   output logic            overrun_tick
);

   localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W  = (DBIT > 2) ? $clog2(DBIT) : 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DBIT - 1);
   localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DBIT-1:0]   shift_q, shift_d;
   logic              pend_q, pend_d;
   logic [DBIT-1:0]   pdata_q, pdata_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              ov_q, ov_d;

   logic bit_end;
   logic last_stop;

   assign bit_end   = (baud_q == BAUD_LAST);
   assign last_stop = (state_q == STOP) && bit_end && (idx_q == STOP_LAST);

   // Next-state, pending-buffer and registered-output decode
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      pend_d  = pend_q;
      pdata_d = pdata_q;
      ov_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (tx_start) begin
               shift_d = din;
               baud_d  = '0;
               idx_d   = '0;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               baud_d  = '0;
               state_d = DATA;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_d  = '0;
               shift_d = shift_q >> 1;
               if (idx_q == DATA_LAST) begin
                  idx_d   = '0;
                  state_d = STOP;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         STOP: begin
            if (bit_end) begin
               baud_d = '0;
               if (idx_q == STOP_LAST) begin
                  idx_d = '0;
                  if (pend_q) begin
                     shift_d = pdata_q;
                     pend_d  = 1'b0;
                     state_d = START;
                  end else if (tx_start) begin
                     shift_d = din;
                     state_d = START;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Requests during a frame: queue one, drop the rest; the slot frees on the last stop cycle
      if (tx_start && (state_q != IDLE)) begin
         if (last_stop) begin
            if (pend_q) begin
               pend_d  = 1'b1;
               pdata_d = din;
            end
         end else if (!pend_q) begin
            pend_d  = 1'b1;
            pdata_d = din;
         end else begin
            ov_d = 1'b1;
         end
      end

      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE) || pend_d;
      done_d = (state_d == STOP) && (baud_d == BAUD_LAST) && (idx_d == STOP_LAST);
   end

   always_ff @(posedge clk_100MHz or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         baud_q  <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         pend_q  <= 1'b0;
         pdata_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         pend_q  <= pend_d;
         pdata_q <= pdata_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ov_q    <= ov_d;
      end
   end

   assign tx           = tx_q;
   assign tx_busy      = busy_q;
   assign tx_done_tick = done_q;
   assign overrun_tick = ov_q;

endmodule

// File: tb/tb_uart_tx_trigger.sv
// Bench for uart_tx_trigger: frame-timeline model for two stop-bit settings,
// a line decoder on the 1-stop instance, and directed literal checks.
module tb_uart_tx_trigger;

   localparam int CPB = 4;
   localparam int DB  = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic       tx_start;
   logic [7:0] din;
   logic       tx1, busy1, done1, ov1;
   logic       tx2, busy2, done2, ov2;

   always #5 clk = ~clk;

   uart_tx_trigger #(.CLKS_PER_BIT(CPB), .DBIT(DB), .STOP_BITS(1)) u1 (
      .clk_100MHz(clk), .reset(reset), .tx_start(tx_start), .din(din),
      .tx(tx1), .tx_busy(busy1), .tx_done_tick(done1), .overrun_tick(ov1));

   uart_tx_trigger #(.CLKS_PER_BIT(CPB), .DBIT(DB), .STOP_BITS(2)) u2 (
      .clk_100MHz(clk), .reset(reset), .tx_start(tx_start), .din(din),
      .tx(tx2), .tx_busy(busy2), .tx_done_tick(done2), .overrun_tick(ov2));

   int checks, errors, cyc;

   // Model: the frame on the line is (start cycle, byte); one byte may wait behind it
   bit         m_act [2];
   int         m_t0  [2];
   logic [7:0] m_byte[2];
   bit         m_pv  [2];
   logic [7:0] m_pd  [2];
   logic       e_tx[2], e_busy[2], e_done[2], e_ov[2];

   // u1 line decoder
   bit         rx_in, rx_prev;
   int         rx_t0, ov_cnt;
   logic [7:0] rx_sh;
   logic [7:0] rx_q[$];
   int         rx_st[$];

   function automatic int flen(input int i);
      return (1 + DB + ((i == 0) ? 1 : 2)) * CPB;
   endfunction

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, want %b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] rx_byte(input int k);
      if (k < rx_q.size()) return rx_q[k];
      return 8'hxx;
   endfunction

   function automatic int rx_start(input int k);
      if (k < rx_st.size()) return rx_st[k];
      return -1;
   endfunction

   task automatic model_reset(input int i);
      m_act[i] = 1'b0;
      m_pv[i]  = 1'b0;
      e_tx[i]  = 1'b1;
      e_busy[i] = 1'b0;
      e_done[i] = 1'b0;
      e_ov[i]   = 1'b0;
   endtask

   // Advance the model by the inputs seen in cycle c; produce outputs for c+1
   task automatic model_step(input int i, input logic st, input logic [7:0] d, input int c);
      bit was_act, last;
      int off, pos;
      was_act  = m_act[i];
      last     = m_act[i] && (c - m_t0[i] == flen(i) - 1);
      e_ov[i]  = 1'b0;
      if (last) begin
         m_act[i] = 1'b0;
         if (m_pv[i]) begin
            m_act[i] = 1'b1; m_t0[i] = c + 1; m_byte[i] = m_pd[i]; m_pv[i] = 1'b0;
         end
      end
      if (st) begin
         if (!was_act || (last && !m_act[i])) begin
            m_act[i] = 1'b1; m_t0[i] = c + 1; m_byte[i] = d;
         end else if (last || !m_pv[i]) begin
            m_pv[i] = 1'b1; m_pd[i] = d;
         end else begin
            e_ov[i] = 1'b1;
         end
      end
      if (m_act[i]) begin
         off = c + 1 - m_t0[i];
         pos = off / CPB;
         if (pos == 0)       e_tx[i] = 1'b0;
         else if (pos <= DB) e_tx[i] = m_byte[i][pos-1];
         else                e_tx[i] = 1'b1;
         e_done[i] = (off == flen(i) - 1);
      end else begin
         e_tx[i]   = 1'b1;
         e_done[i] = 1'b0;
      end
      e_busy[i] = m_act[i] || m_pv[i];
   endtask

   task automatic monitor();
      int off;
      if (!reset) begin
         model_reset(0);
         model_reset(1);
      end
      chk1("u1.tx", tx1, e_tx[0]);     chk1("u1.busy", busy1, e_busy[0]);
      chk1("u1.done", done1, e_done[0]); chk1("u1.overrun", ov1, e_ov[0]);
      chk1("u2.tx", tx2, e_tx[1]);     chk1("u2.busy", busy2, e_busy[1]);
      chk1("u2.done", done2, e_done[1]); chk1("u2.overrun", ov2, e_ov[1]);
      if (reset) begin
         model_step(0, tx_start, din, cyc);
         model_step(1, tx_start, din, cyc);
      end
      if (!reset) begin
         rx_in = 1'b0;
      end else if (!rx_in) begin
         if (!tx1 && rx_prev) begin
            rx_in = 1'b1; rx_t0 = cyc; rx_sh = '0;
         end
      end else begin
         off = cyc - rx_t0;
         if (off >= 6 && off <= 34 && ((off - 6) % 4) == 0) rx_sh[(off-6)/4] = tx1;
         if (off == 38) begin
            rx_q.push_back(rx_sh);
            rx_st.push_back(rx_t0);
            rx_in = 1'b0;
         end
      end
      rx_prev = tx1;
      if (ov1 === 1'b1) ov_cnt++;
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic pulse_at(input int t, input logic [7:0] d);
      while (cyc < t) tick();
      tx_start = 1'b1;
      din      = d;
      tick();
      tx_start = 1'b0;
      din      = 8'($urandom);
   endtask

   logic lv[10];
   int   s, b, o;

   initial begin
      reset = 1'b0; tx_start = 1'b0; din = 8'h00;
      checks = 0; errors = 0; cyc = 0;
      rx_in = 1'b0; rx_prev = 1'b1; ov_cnt = 0;
      lv = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      @(posedge clk); #1;
      repeat (2) tick();
      chk1("rst.tx", tx1, 1'b1);   chk1("rst.busy", busy1, 1'b0);
      chk1("rst.done", done1, 1'b0); chk1("rst.overrun", ov1, 1'b0);
      reset = 1'b1;
      repeat (3) tick();

      // Single byte A5, 1 stop bit
      b = rx_q.size(); s = cyc + 2;
      pulse_at(s, 8'hA5);
      for (int i = 1; i <= 41; i++) begin
         if (i <= 40) chk1("a5.level", tx1, lv[(i-1)/4]);
         chk1("a5.done", done1, (i == 40));
         if (i == 41) chk1("a5.idle_busy", busy1, 1'b0);
         tick();
      end
      while (cyc < s + 100) tick();
      chki("a5.frames", rx_q.size() - b, 1);
      chk8("a5.byte", rx_byte(b), 8'hA5);

      // Back-to-back 55 then 0F
      b = rx_q.size(); o = ov_cnt; s = cyc + 2;
      pulse_at(s, 8'h55);
      pulse_at(s + 10, 8'h0F);
      while (cyc < s + 120) tick();
      chki("b2b.frames", rx_q.size() - b, 2);
      chk8("b2b.byte0", rx_byte(b), 8'h55);
      chk8("b2b.byte1", rx_byte(b + 1), 8'h0F);
      chki("b2b.latency", rx_start(b) - s, 1);
      chki("b2b.gap", rx_start(b + 1) - rx_start(b), 40);
      chki("b2b.overruns", ov_cnt - o, 0);

      // Overrun: third request inside one frame is dropped
      b = rx_q.size(); o = ov_cnt; s = cyc + 2;
      pulse_at(s, 8'h01);
      pulse_at(s + 5, 8'h02);
      pulse_at(s + 10, 8'h03);
      while (cyc < s + 130) tick();
      chki("ovr.frames", rx_q.size() - b, 2);
      chk8("ovr.byte0", rx_byte(b), 8'h01);
      chk8("ovr.byte1", rx_byte(b + 1), 8'h02);
      chki("ovr.overruns", ov_cnt - o, 1);

      // Request coincident with the done tick
      b = rx_q.size(); o = ov_cnt; s = cyc + 2;
      pulse_at(s, 8'h3C);
      while (cyc < s + 40) tick();
      chk1("bnd.done_now", done1, 1'b1);
      pulse_at(s + 40, 8'hC3);
      while (cyc < s + 130) tick();
      chki("bnd.frames", rx_q.size() - b, 2);
      chk8("bnd.byte1", rx_byte(b + 1), 8'hC3);
      chki("bnd.gap", rx_start(b + 1) - rx_start(b), 40);
      chki("bnd.overruns", ov_cnt - o, 0);

      // Reset during data bit 3 of FF with 77 pending
      b = rx_q.size(); s = cyc + 2;
      pulse_at(s, 8'hFF);
      pulse_at(s + 3, 8'h77);
      while (cyc < s + 18) tick();
      chk1("rstmid.busy_before", busy1, 1'b1);
      reset = 1'b0;
      #1;
      chk1("rstmid.tx1", tx1, 1'b1);   chk1("rstmid.busy1", busy1, 1'b0);
      chk1("rstmid.done1", done1, 1'b0); chk1("rstmid.ov1", ov1, 1'b0);
      chk1("rstmid.tx2", tx2, 1'b1);   chk1("rstmid.busy2", busy2, 1'b0);
      repeat (3) tick();
      reset = 1'b1;
      while (cyc < s + 120) tick();
      chki("rstmid.frames", rx_q.size() - b, 0);
      chk1("rstmid.busy_after", busy1, 1'b0);

      // Two stop bits, byte 00
      s = cyc + 2;
      pulse_at(s, 8'h00);
      for (int i = 1; i <= 45; i++) begin
         if (i <= 44) chk1("stop2.level", tx2, (i > 36));
         chk1("stop2.done", done2, (i == 44));
         if (i == 45) chk1("stop2.idle_busy", busy2, 1'b0);
         tick();
      end
      while (cyc < s + 60) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
